// File: rtl/mgc_io_pkg.sv
// ---------------------------------------------------------------------------
// mgc_io_pkg
// Shared constants for the mgc interface resources (input and output wait
// FIFOs).
//   PH_HIGH / PH_LOW : polarity values for the ph_en / ph_srst parameters
//   MGC_SIZE_W       : width of the zero-extended occupancy port
// ---------------------------------------------------------------------------
package mgc_io_pkg;

    localparam logic PH_HIGH    = 1'b1;
    localparam logic PH_LOW     = 1'b0;
    localparam int   MGC_SIZE_W = 32;

endpackage : mgc_io_pkg

// File: rtl/mgc_in_fifo_wait_rdy_if.sv
// ---------------------------------------------------------------------------
// mgc_in_fifo_wait_rdy_if
// Handshake bundle between a producer / consuming design and the input wait
// FIFO.
//   vz   : producer data valid          lz   : ready to producer
//   z    : producer data                ld   : design read request
//   vd   : word available to design     d    : head-of-FIFO data
//   size : current occupancy, zero-extended to MGC_SIZE_W bits
// Modports:
//   slave  : the FIFO side (drives lz, vd, d, size)
//   master : the environment side (drives vz, z, ld)
// ---------------------------------------------------------------------------
interface mgc_in_fifo_wait_rdy_if
    import mgc_io_pkg::*;
#(
    parameter int width = 8
) ();

    logic                  vz;
    logic [width-1:0]      z;
    logic                  lz;
    logic                  ld;
    logic                  vd;
    logic [width-1:0]      d;
    logic [MGC_SIZE_W-1:0] size;

    modport slave (
        input  vz,
        input  z,
        input  ld,
        output lz,
        output vd,
        output d,
        output size
    );

    modport master (
        output vz,
        output z,
        output ld,
        input  lz,
        input  vd,
        input  d,
        input  size
    );

endinterface : mgc_in_fifo_wait_rdy_if

// File: rtl/mgc_fifo_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// mgc_fifo_ptr_ctrl
// Read/write pointers, occupancy count and full/empty flags for a circular
// buffer of fifo_sz entries. Depths that are not powers of two are handled by
// wrapping explicitly at fifo_sz-1 instead of relying on pointer overflow.
// Shared by the input and output wait FIFOs.
// Ports:
//   clk, arst        : clock, asynchronous active-low reset
//   en_act, srst_act : already-decoded enable / synchronous reset (active high)
//   push, pop        : qualified handshake events for this cycle
//   wr_ptr, rd_ptr   : current pointers
//   count            : current occupancy (0 .. fifo_sz)
//   full, empty      : occupancy flags decoded from count
// ---------------------------------------------------------------------------
module mgc_fifo_ptr_ctrl
    import mgc_io_pkg::*;
#(
    parameter int fifo_sz = 8,
    parameter int ph_log2 = 3
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               en_act,
    input  logic               srst_act,
    input  logic               push,
    input  logic               pop,
    output logic [ph_log2-1:0] wr_ptr,
    output logic [ph_log2-1:0] rd_ptr,
    output logic [ph_log2:0]   count,
    output logic               full,
    output logic               empty
);

    localparam int                 CNT_W   = ph_log2 + 1;
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(fifo_sz);
    localparam logic [ph_log2-1:0] LAST_C  = ph_log2'(fifo_sz - 1);

    logic [ph_log2-1:0] wr_ptr_r;
    logic [ph_log2-1:0] rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [ph_log2-1:0] wr_ptr_nxt_s;
    logic [ph_log2-1:0] rd_ptr_nxt_s;
    logic [CNT_W-1:0]   count_nxt_s;

    // Advance a pointer, wrapping after the last real slot.
    function automatic logic [ph_log2-1:0] ptr_next(input logic [ph_log2-1:0] ptr);
        logic [ph_log2-1:0] nxt;
        if (ptr == LAST_C) begin
            nxt = {ph_log2{1'b0}};
        end else begin
            nxt = ptr + ph_log2'(1);
        end
        return nxt;
    endfunction

    // Next-state for pointers and count; srst wins over en.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (srst_act) begin
            wr_ptr_nxt_s = {ph_log2{1'b0}};
            rd_ptr_nxt_s = {ph_log2{1'b0}};
            count_nxt_s  = {CNT_W{1'b0}};
        end else if (en_act) begin
            if (push) begin
                wr_ptr_nxt_s = ptr_next(wr_ptr_r);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_nxt_s = ptr_next(rd_ptr_r);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            case ({push, pop})
                2'b10:   count_nxt_s = count_r + CNT_W'(1);
                2'b01:   count_nxt_s = count_r - CNT_W'(1);
                default: count_nxt_s = count_r;
            endcase
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
            rd_ptr_nxt_s = rd_ptr_r;
            count_nxt_s  = count_r;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_ptr_r <= {ph_log2{1'b0}};
            rd_ptr_r <= {ph_log2{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    assign wr_ptr = wr_ptr_r;
    assign rd_ptr = rd_ptr_r;
    assign count  = count_r;
    assign full   = (count_r == DEPTH_C);
    assign empty  = (count_r == {CNT_W{1'b0}});

endmodule : mgc_fifo_ptr_ctrl

// File: rtl/mgc_in_fifo_wait_rdy.sv
// ---------------------------------------------------------------------------
// mgc_in_fifo_wait_rdy
// Input-side wait FIFO: accepts words from an external producer over a
// valid/ready handshake (vz/lz) and presents them to the design, which pops
// them with ld/vd. Holds up to fifo_sz words.
// Ports:
//   clk   : clock, rising edge
//   arst  : asynchronous reset, active low
//   en    : clock enable, active level ph_en
//   srst  : synchronous reset, active level ph_srst (overrides en)
//   io    : mgc_in_fifo_wait_rdy_if.slave (vz, z, lz, ld, vd, d, size)
// Build option:
//   MGC_IN_FIFO_BYPASS_EN : when defined, an empty FIFO forwards z straight to
//   d and raises vd from vz in the same cycle; a word consumed that way is
//   neither pushed nor popped.
// ---------------------------------------------------------------------------
module mgc_in_fifo_wait_rdy
    import mgc_io_pkg::*;
#(
    parameter int   rscid   = 0,
    parameter int   width   = 8,
    parameter int   fifo_sz = 8,
    parameter int   ph_log2 = 3,
    parameter logic ph_en   = PH_HIGH,
    parameter logic ph_srst = PH_HIGH
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic                         en,
    input  logic                         srst,
    mgc_in_fifo_wait_rdy_if.slave        io
);

    // rscid is a tag for tools only; an out-of-range parameter set shows up as
    // this extra (empty) scope in the elaborated hierarchy.
    if ((fifo_sz < 1) || (ph_log2 < 1) || (rscid < 0)) begin : g_illegal_params
    end

    logic [width-1:0]   mem [fifo_sz];

    logic               en_act_s;
    logic               srst_act_s;
    logic               lz_s;
    logic               vd_s;
    logic               thru_s;
    logic               push_s;
    logic               pop_s;
    logic [width-1:0]   d_s;
    logic [ph_log2-1:0] wr_ptr_s;
    logic [ph_log2-1:0] rd_ptr_s;
    logic [ph_log2:0]   count_s;
    logic               full_s;
    logic               empty_s;

    assign en_act_s   = (en == ph_en);
    assign srst_act_s = (srst == ph_srst);

    mgc_fifo_ptr_ctrl #(
        .fifo_sz (fifo_sz),
        .ph_log2 (ph_log2)
    ) u_ptr_ctrl (
        .clk      (clk),
        .arst     (arst),
        .en_act   (en_act_s),
        .srst_act (srst_act_s),
        .push     (push_s),
        .pop      (pop_s),
        .wr_ptr   (wr_ptr_s),
        .rd_ptr   (rd_ptr_s),
        .count    (count_s),
        .full     (full_s),
        .empty    (empty_s)
    );

    // Handshake flags. lz looks only at the registered count, so a pop on a
    // full FIFO frees the slot for the producer one cycle later. arst is
    // folded in so both flags are low for the whole reset assertion.
    always_comb begin
        lz_s   = arst & en_act_s & ~full_s;
`ifdef MGC_IN_FIFO_BYPASS_EN
        vd_s   = arst & en_act_s & (~empty_s | io.vz);
        thru_s = empty_s & io.vz & io.ld & vd_s;
`else
        vd_s   = arst & en_act_s & ~empty_s;
        thru_s = 1'b0;
`endif
        push_s = io.vz & lz_s & ~thru_s;
        pop_s  = io.ld & vd_s & ~empty_s;
    end

    // Head-of-FIFO data, forced to zero whenever nothing is on offer.
    always_comb begin
        d_s = {width{1'b0}};
        if (vd_s) begin
`ifdef MGC_IN_FIFO_BYPASS_EN
            if (empty_s) begin
                d_s = io.z;
            end else begin
                d_s = mem[rd_ptr_s];
            end
`else
            d_s = mem[rd_ptr_s];
`endif
        end else begin
            d_s = {width{1'b0}};
        end
    end

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem[wr_ptr_s] <= io.z;
        end
    end

    assign io.lz   = lz_s;
    assign io.vd   = vd_s;
    assign io.d    = d_s;
    assign io.size = MGC_SIZE_W'(count_s);

endmodule : mgc_in_fifo_wait_rdy

// File: tb/tb_mgc_in_fifo_wait_rdy.sv
// ---------------------------------------------------------------------------
// tb_mgc_in_fifo_wait_rdy
// Directed bench for mgc_in_fifo_wait_rdy. Two instances share clock, reset,
// enable and srst: u_dut4 (fifo_sz=4) covers reset, fill, drain order, enable
// gating and the empty-read case; u_dut3 (fifo_sz=3) covers full with a
// same-cycle pop, streaming across the pointer wrap and mid-stream srst.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2
// units later, well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_mgc_in_fifo_wait_rdy;

    logic clk = 1'b0;
    logic arst;
    logic en;
    logic srst;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] q[$];

    always #5 clk = ~clk;

    mgc_in_fifo_wait_rdy_if #(.width(8)) io4 ();
    mgc_in_fifo_wait_rdy_if #(.width(8)) io3 ();

    mgc_in_fifo_wait_rdy #(
        .rscid (1), .width (8), .fifo_sz (4), .ph_log2 (2),
        .ph_en (1'b1), .ph_srst (1'b1)
    ) u_dut4 (
        .clk (clk), .arst (arst), .en (en), .srst (srst), .io (io4.slave)
    );

    mgc_in_fifo_wait_rdy #(
        .rscid (2), .width (8), .fifo_sz (3), .ph_log2 (2),
        .ph_en (1'b1), .ph_srst (1'b1)
    ) u_dut3 (
        .clk (clk), .arst (arst), .en (en), .srst (srst), .io (io3.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst = 1'b0; en = 1'b1; srst = 1'b0;
        io4.vz = 1'b0; io4.z = 8'h00; io4.ld = 1'b0;
        io3.vz = 1'b0; io3.z = 8'h00; io3.ld = 1'b0;

        // ---------------- reset ----------------
        repeat (3) step();
        #2;
        check("rst_lz",   io4.lz,   32'd0);
        check("rst_vd",   io4.vd,   32'd0);
        check("rst_d",    io4.d,    32'd0);
        check("rst_size", io4.size, 32'd0);
        arst = 1'b1;
        #2;
        check("post_rst_lz",   io4.lz,   32'd1);
        check("post_rst_vd",   io4.vd,   32'd0);
        check("post_rst_d",    io4.d,    32'd0);
        check("post_rst_size", io4.size, 32'd0);
        step();

        // ---------------- fill (fifo_sz=4) ----------------
        for (int i = 0; i < 4; i++) begin
            io4.vz = 1'b1;
            io4.z  = 8'(8'h11 * (i + 1));
            #2;
            check("fill_lz", io4.lz, 32'd1);
            step();
            #2;
            check("fill_size", io4.size, 32'(i + 1));
        end
        check("full_lz", io4.lz, 32'd0);
        check("full_vd", io4.vd, 32'd1);
        check("full_d",  io4.d,  32'h11);
        io4.z = 8'h55;
        step();
        step();
        #2;
        check("held_size", io4.size, 32'd4);
        check("held_lz",   io4.lz,   32'd0);
        check("held_d",    io4.d,    32'h11);

        // ---------------- drain order ----------------
        io4.vz = 1'b0;
        io4.ld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("drain_vd", io4.vd, 32'd1);
            check("drain_d",  io4.d,  32'(8'(8'h11 * (i + 1))));
            step();
        end
        #2;
        check("drained_vd",   io4.vd,   32'd0);
        check("drained_d",    io4.d,    32'd0);
        check("drained_size", io4.size, 32'd0);
        check("drained_lz",   io4.lz,   32'd1);
        io4.ld = 1'b0;

        // ---------------- enable gating ----------------
        io4.vz = 1'b1; io4.z = 8'h66;
        step();
        io4.vz = 1'b0;
        en = 1'b0;
        #2;
        check("en_off_lz",   io4.lz,   32'd0);
        check("en_off_vd",   io4.vd,   32'd0);
        check("en_off_d",    io4.d,    32'd0);
        check("en_off_size", io4.size, 32'd1);
        io4.vz = 1'b1; io4.z = 8'h77; io4.ld = 1'b1;
        step();
        #2;
        check("en_off_hold", io4.size, 32'd1);
        en = 1'b1; io4.vz = 1'b0; io4.ld = 1'b0;
        #2;
        check("en_on_vd", io4.vd, 32'd1);
        check("en_on_d",  io4.d,  32'h66);
        io4.ld = 1'b1;
        step();
        io4.ld = 1'b0;
        #2;
        check("en_pop_size", io4.size, 32'd0);

        // ---------------- empty with vz & ld ----------------
        io4.vz = 1'b1; io4.z = 8'hA5; io4.ld = 1'b1;
`ifdef MGC_IN_FIFO_BYPASS_EN
        #2;
        check("byp_vd", io4.vd, 32'd1);
        check("byp_d",  io4.d,  32'hA5);
        check("byp_lz", io4.lz, 32'd1);
        step();
        io4.vz = 1'b0; io4.ld = 1'b0;
        #2;
        check("byp_size", io4.size, 32'd0);
        check("byp_vd0",  io4.vd,   32'd0);
`else
        #2;
        check("empty_rd_vd", io4.vd, 32'd0);
        check("empty_rd_d",  io4.d,  32'd0);
        step();
        io4.vz = 1'b0; io4.ld = 1'b0;
        #2;
        check("empty_rd_size", io4.size, 32'd1);
        check("latency_vd",    io4.vd,   32'd1);
        check("latency_d",     io4.d,    32'hA5);
        io4.ld = 1'b1;
        step();
        io4.ld = 1'b0;
`endif

        // ---------------- full with same-cycle pop (fifo_sz=3) ----------------
        for (int i = 0; i < 3; i++) begin
            io3.vz = 1'b1;
            io3.z  = 8'(8'hA1 + i);
            q.push_back(io3.z);
            step();
        end
        #2;
        check("f3_size", io3.size, 32'd3);
        check("f3_lz",   io3.lz,   32'd0);
        io3.vz = 1'b1; io3.z = 8'hA4; io3.ld = 1'b1;
        #2;
        check("f3_pop_lz", io3.lz, 32'd0);
        check("f3_pop_d",  io3.d,  32'(q[0]));
        step();
        void'(q.pop_front());
        #2;
        check("f3_after_pop_size", io3.size, 32'd2);
        check("f3_after_pop_lz",   io3.lz,   32'd1);
        io3.ld = 1'b0;
        step();
        q.push_back(8'hA4);
        #2;
        check("f3_refill_size", io3.size, 32'd3);
        io3.vz = 1'b0; io3.ld = 1'b1;
        #2;
        check("f3_pop2_d", io3.d, 32'(q[0]));
        step();
        void'(q.pop_front());
        #2;
        check("f3_pop2_size", io3.size, 32'd2);

        // ---------------- streaming across the wrap ----------------
        for (int i = 0; i < 10; i++) begin
            io3.vz = 1'b1; io3.z = 8'(8'hB0 + i); io3.ld = 1'b1;
            #2;
            check("wrap_d",  io3.d,  32'(q[0]));
            check("wrap_lz", io3.lz, 32'd1);
            step();
            void'(q.pop_front());
            q.push_back(8'(8'hB0 + i));
            #2;
            check("wrap_size", io3.size, 32'd2);
        end

        // ---------------- mid-stream srst ----------------
        io3.ld = 1'b0; io3.vz = 1'b1; io3.z = 8'hC0;
        step();
        #2;
        check("srst_pre_size", io3.size, 32'd3);
        io3.vz = 1'b0;
        srst = 1'b1;
        step();
        srst = 1'b0;
        #2;
        check("srst_size", io3.size, 32'd0);
        check("srst_vd",   io3.vd,   32'd0);
        check("srst_d",    io3.d,    32'd0);
        check("srst_lz",   io3.lz,   32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mgc_in_fifo_wait_rdy
